// File: rtl/ser_pkg.sv
// Shared types and defaults for the serial stimulus stage that feeds the sequence detectors.
// S_PARITY exists in every build so the state encoding stays the same whether SER_PARITY_EN is defined or not.
package ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } ser_state_e;

    localparam int SER_W_DEF = 8;

endpackage

// File: rtl/inp_serializer.sv
// Parallel-to-serial stage: takes words over valid/ready and shifts them out on INP one bit per clock.
// Optional macro SER_PARITY_EN appends one even-parity bit to every word.
//
// state    | meaning
// S_IDLE   | nothing in flight, INP at IDLE_LVL, ready for a word
// S_SHIFT  | INP carries payload bit cnt_q of the current word
// S_PARITY | INP carries the parity bit (SER_PARITY_EN only)
module inp_serializer
    import ser_pkg::*;
#(
    parameter int W         = SER_W_DEF,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_LVL  = 1'b0
) (
    input  logic         clk,
    input  logic         nres,
    input  logic [W-1:0] data_in,
    input  logic         data_valid,
    output logic         data_ready,
    output logic         INP,
    output logic         bit_valid,
    output logic         busy
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    ser_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_q, sh_d;
    logic          inp_q, inp_d;
    logic          bv_q, bv_d;
    logic          open_c;
    logic          accept_c;
`ifdef SER_PARITY_EN
    logic          par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        inp_d   = inp_q;
        bv_d    = bv_q;
`ifdef SER_PARITY_EN
        par_d   = par_q;
`endif
        // open_c marks the cycles in which a new word may be taken: idle, or the last bit of a word.
        case (state_q)
            S_IDLE:  open_c = 1'b1;
`ifdef SER_PARITY_EN
            S_SHIFT: open_c = 1'b0;
`else
            S_SHIFT: open_c = (cnt_q == CNT_LAST);
`endif
            default: open_c = 1'b1;
        endcase
        data_ready = open_c & nres;
        accept_c   = data_valid & data_ready;

        if (accept_c) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            inp_d   = MSB_FIRST ? data_in[W-1] : data_in[0];
            sh_d    = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
            bv_d    = 1'b1;
`ifdef SER_PARITY_EN
            par_d   = ^data_in;
`endif
        end else begin
            case (state_q)
                S_IDLE: ;
                S_SHIFT: begin
                    if (cnt_q == CNT_LAST) begin
`ifdef SER_PARITY_EN
                        state_d = S_PARITY;
                        inp_d   = par_q;
                        bv_d    = 1'b1;
`else
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        inp_d   = IDLE_LVL;
                        bv_d    = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        inp_d = MSB_FIRST ? sh_q[W-1] : sh_q[0];
                        sh_d  = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    inp_d   = IDLE_LVL;
                    bv_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            inp_q   <= IDLE_LVL;
            bv_q    <= 1'b0;
`ifdef SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            inp_q   <= inp_d;
            bv_q    <= bv_d;
`ifdef SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign INP       = inp_q;
    assign bit_valid = bv_q;
    assign busy      = (state_q != S_IDLE);

endmodule
